rom_loader: RTL and testbench



---
 rtl/rom_loader.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rom_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: buffers HPS ioctl ROM bytes into the core's ROM write port, captures mod/DIP bytes, sequences core_reset.
// Latency: a ROM byte sampled at edge k with the FIFO empty and the output stage idle appears on rom_wr after edge k+1.
// Backpressure: rom_ready stalls the output register; ioctl_wait rises once post-edge occupancy reaches FIFO_DEPTH-1.
//
// Ports:
//   clk_sys, reset_n                      sole clock, async active-low reset
//   ioctl_download/index/wr/addr/dout     HPS download stream in
//   ioctl_wait                            back-pressure to HPS
//   rom_wr/rom_addr/rom_data, rom_ready   valid/ready ROM write port to the core
//   mod, dip_sw                           game-select byte (index 1), DIP bytes (index 254)
//   core_reset, load_done                 core reset request, end-of-hold pulse
//   rom_bytes, rom_sum, err_ovf           load statistics and sticky overflow flag

// rom_loader_fifo: small circular buffer for {addr, data} words.
// Latency: head is valid the cycle after a push into an empty buffer; read is combinational from the head slot.
// Backpressure: none internally; the owner must not push when count == DEPTH nor pop when count == 0.
module rom_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage carries no reset: only slots behind a valid count are ever read.
  always_ff @(posedge clk_sys) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_rdy) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_vld, pop_rdy})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module rom_loader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 16,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  input  logic              rom_ready,
  output logic [7:0]        mod,
  output logic [63:0]       dip_sw,
  output logic              core_reset,
  output logic [ADDR_W:0]   rom_bytes,
  output logic [15:0]       rom_sum,
  output logic              load_done,
  output logic              err_ovf
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ADDR_W + 8;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0]   CNT_ONE   = 1;
  localparam logic [CW-1:0]   CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   CNT_WAIT  = CW'(FIFO_DEPTH - 1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_ONE  = 1;
  localparam logic [ADDR_W:0] BYTES_ONE = 1;
  localparam logic [32:0]     ADDR_LIM  = 33'd1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;

  // rom_load is registered before edge detection, so LOAD is entered on
  // the edge after rom_load is first sampled high.
  logic load_q;
  logic load_qq;
  logic load_rise;

  logic          in_range;
  logic          accept;
  logic          push;
  logic          drop;
  logic          pop;
  logic          stage_load;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [FW-1:0] fifo_head;

  assign load_rise = load_q && !load_qq;

  // 33-bit compare keeps the bound valid for any ADDR_W up to 25.
  assign in_range = ({8'd0, ioctl_addr} < ADDR_LIM);
  assign accept   = ioctl_wr && (ioctl_index == 8'd0) && (state == S_LOAD) && in_range;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_FULL);

  // Fullness is judged before the edge: a byte arriving at a full FIFO is
  // dropped even if the output stage frees a slot on the same edge.
  assign push = accept && !fifo_full;
  assign drop = accept && fifo_full;

  // The holding register reloads when it is empty or its word transfers now.
  assign stage_load = !rom_wr || rom_ready;
  assign pop        = stage_load && !fifo_empty;

  always_comb begin
    cnt_nxt = fifo_cnt;
    if (push && !pop) begin
      cnt_nxt = fifo_cnt + CNT_ONE;
    end else if (!push && pop) begin
      cnt_nxt = fifo_cnt - CNT_ONE;
    end
  end

  rom_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .push_vld (push),
    .push_dat ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
    .pop_rdy  (pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  // Download-select sampling.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      load_q  <= 1'b0;
      load_qq <= 1'b0;
    end else begin
      load_q  <= ioctl_download && (ioctl_index == 8'd0);
      load_qq <= load_q;
    end
  end

  // Output holding register; address/data only move when a new word loads,
  // so they stay stable across a stall.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_wr   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else if (stage_load) begin
      rom_wr <= !fifo_empty;
      if (!fifo_empty) begin
        {rom_addr, rom_data} <= fifo_head;
      end
    end
  end

  // Post-edge occupancy drives ioctl_wait, leaving room for one more write.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
    end else begin
      ioctl_wait <= (cnt_nxt >= CNT_WAIT);
    end
  end

  // Load statistics; a new load clears them, a dropped byte is not counted.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_bytes <= '0;
      rom_sum   <= '0;
      err_ovf   <= 1'b0;
    end else if (load_rise) begin
      rom_bytes <= '0;
      rom_sum   <= '0;
      err_ovf   <= 1'b0;
    end else begin
      if (push) begin
        rom_bytes <= rom_bytes + BYTES_ONE;
        rom_sum   <= rom_sum + {8'd0, ioctl_dout};
      end
      if (drop) begin
        err_ovf <= 1'b1;
      end
    end
  end

  // Side registers: game select and DIP bytes, independent of the FSM.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mod    <= '0;
      dip_sw <= '0;
    end else if (ioctl_wr) begin
      if (ioctl_index == 8'd1) begin
        mod <= ioctl_dout;
      end
      if ((ioctl_index == 8'd254) && (ioctl_addr[24:3] == '0)) begin
        dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
    end
  end

  // Load sequencer. A fresh load request wins in any state; in DRAIN the
  // queued bytes keep flowing since the FIFO and output stage are untouched.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      core_reset <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_rise) begin
        state      <= S_LOAD;
        core_reset <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_LOAD: begin
            if (!load_q) begin
              state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (fifo_empty && !rom_wr) begin
              state    <= S_HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              state      <= S_IDLE;
              core_reset <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed + randomized checks of rom_loader against a queue/arithmetic reference.
// Stimulus is driven 1 time unit after the rising edge; outputs are read there or at the falling edge.
// A falling-edge monitor records every ROM write transfer and checks stall stability.
module tb_rom_loader;
  localparam int FIFO_DEPTH  = 4;
  localparam int ADDR_W      = 16;
  localparam int HOLD_CYCLES = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = 8'd0;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic              ioctl_wait;
  logic              rom_wr;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              rom_ready = 1'b0;
  logic [7:0]        mod;
  logic [63:0]       dip_sw;
  logic              core_reset;
  logic [ADDR_W:0]   rom_bytes;
  logic [15:0]       rom_sum;
  logic              load_done;
  logic              err_ovf;

  rom_loader #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ADDR_W      (ADDR_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_wr         (rom_wr),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_ready      (rom_ready),
    .mod            (mod),
    .dip_sw         (dip_sw),
    .core_reset     (core_reset),
    .rom_bytes      (rom_bytes),
    .rom_sum        (rom_sum),
    .load_done      (load_done),
    .err_ovf        (err_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_last = 0;

  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];

  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [7:0]        prev_data;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic start_load();
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    for (int n = 0; n < 10 && !core_reset; n++) tick();
    chk("load_entry", 64'(core_reset), 64'd1);
  endtask

  task automatic end_load();
    logic seen;
    seen = 1'b0;
    ioctl_download = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      seen = load_done;
    end
    chk("load_done_seen", 64'(seen), 64'd1);
  endtask

  // Transfer recorder: a word sampled here with rom_wr && rom_ready is
  // accepted on the next rising edge (cycle cyc+1).
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (prev_stall) begin
        chk("stall_vld", 64'(rom_wr), 64'd1);
        chk("stall_addr", 64'(rom_addr), 64'(prev_addr));
        chk("stall_data", 64'(rom_data), 64'(prev_data));
      end
      if (rom_wr && rom_ready) begin
        got_q.push_back({rom_addr, rom_data});
        t_last = cyc + 1;
      end
      prev_stall = rom_wr && !rom_ready;
      prev_addr  = rom_addr;
      prev_data  = rom_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int          fall_cyc;
    int          sent;
    int          m_n;
    logic [15:0] m_sum;
    logic [24:0] a;
    logic [7:0]  d;
    logic        seen;
    logic [63:0] exp_wait;

    // ---------------- reset state ----------------
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_rom_wr", 64'(rom_wr), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd0);
    chk("rst_mod", 64'(mod), 64'd0);
    chk("rst_dip", dip_sw, 64'd0);
    chk("rst_bytes", 64'(rom_bytes), 64'd0);
    chk("rst_sum", 64'(rom_sum), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_ovf", 64'(err_ovf), 64'd0);

    // ---------------- basic load ----------------
    rom_ready      = 1'b1;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    chk("crst_not_yet", 64'(core_reset), 64'd0);
    tick();
    chk("crst_rise", 64'(core_reset), 64'd1);
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      wr(8'd0, 25'(i), 8'(i + 1));
      if (i == 0) begin
        chk("lat_before", 64'(rom_wr), 64'd0);
        tick();
        chk("lat_vld", 64'(rom_wr), 64'd1);
        chk("lat_addr", 64'(rom_addr), 64'd0);
        chk("lat_data", 64'(rom_data), 64'd1);
        repeat (2) tick();
      end else if (i < 15) begin
        repeat (3) tick();
      end
    end
    ioctl_download = 1'b0;
    for (int n = 0; n < 100 && core_reset; n++) tick();
    fall_cyc = cyc;
    // HOLD starts on the first edge after the last transfer (rom_wr low, FIFO
    // empty, download already dropped); core_reset then falls HOLD_CYCLES later.
    chk("crst_fall_cyc", 64'(fall_cyc), 64'(t_last + 1 + HOLD_CYCLES));
    chk("crst_fall", 64'(core_reset), 64'd0);
    chk("done_on_fall", 64'(load_done), 64'd1);
    tick();
    chk("done_pulse_end", 64'(load_done), 64'd0);
    chk("basic_count", 64'(got_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) chk("basic_xfer", 64'(got_q[i]), 64'({16'(i), 8'(i + 1)}));
    end
    chk("basic_bytes", 64'(rom_bytes), 64'd16);
    chk("basic_sum", 64'(rom_sum), 64'h0088);
    chk("basic_ovf", 64'(err_ovf), 64'd0);

    // ---------------- side registers ----------------
    ioctl_download = 1'b1;
    wr(8'd1, 25'd0, 8'h02);
    chk("side_crst0", 64'(core_reset), 64'd0);
    wr(8'd1, 25'd1, 8'h03);
    chk("side_mod", 64'(mod), 64'h03);
    wr(8'd254, 25'd2, 8'hA5);
    chk("side_crst1", 64'(core_reset), 64'd0);
    wr(8'd254, 25'd8, 8'hFF);
    ioctl_download = 1'b0;
    tick();
    chk("side_dip", dip_sw, 64'h0000_0000_00A5_0000);
    chk("side_mod_kept", 64'(mod), 64'h03);
    chk("side_crst2", 64'(core_reset), 64'd0);

    // ---------------- back-pressure ----------------
    rom_ready = 1'b0;
    start_load();
    got_q.delete();
    // Occupancy after each write: 1, 1 (first byte moved to the output), 2, 3, 4, full.
    exp_wait = 64'b111000;
    for (int i = 0; i < 6; i++) begin
      wr(8'd0, 25'(16'h0100 + i), 8'(8'h40 + i));
      chk("bp_wait", 64'(ioctl_wait), 64'(exp_wait[i]));
      chk("bp_ovf", 64'(err_ovf), 64'(i == 5));
    end
    chk("bp_bytes", 64'(rom_bytes), 64'd5);
    chk("bp_sum", 64'(rom_sum), 64'h014A);
    chk("bp_stalled", 64'(rom_wr), 64'd1);
    rom_ready = 1'b1;
    repeat (8) tick();
    chk("bp_count", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) chk("bp_xfer", 64'(got_q[i]), 64'({16'(16'h0100 + i), 8'(8'h40 + i)}));
    end
    chk("bp_wait_clear", 64'(ioctl_wait), 64'd0);
    end_load();

    // ---------------- random stalls against reference ----------------
    start_load();
    got_q.delete();
    exp_q.delete();
    sent  = 0;
    m_n   = 0;
    m_sum = '0;
    for (int c = 0; c < 2000 && sent < 40; c++) begin
      rom_ready = 1'($urandom_range(0, 1));
      if (!ioctl_wait && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) a = 25'(32'h10000 + $urandom_range(0, 255));
        else a = 25'($urandom_range(0, 65535));
        d = 8'($urandom);
        if (a < 25'h10000) begin
          exp_q.push_back({a[15:0], d});
          m_n++;
          m_sum = m_sum + 16'(d);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        sent++;
      end
      tick();
      ioctl_wr = 1'b0;
    end
    ioctl_download = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      rom_ready = 1'($urandom_range(0, 1));
      tick();
      seen = load_done;
    end
    chk("rnd_done", 64'(seen), 64'd1);
    chk("rnd_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk("rnd_xfer", 64'(got_q[i]), 64'(exp_q[i]));
    end
    chk("rnd_bytes", 64'(rom_bytes), 64'(m_n));
    chk("rnd_sum", 64'(rom_sum), 64'(m_sum));
    chk("rnd_ovf", 64'(err_ovf), 64'd0);

    // ---------------- out-of-range and re-entry during HOLD ----------------
    rom_ready = 1'b1;
    start_load();
    got_q.delete();
    wr(8'd0, 25'h10000, 8'h77);
    wr(8'd0, 25'h00010, 8'h5A);
    repeat (3) tick();
    chk("oor_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("oor_xfer", 64'(got_q[0]), 64'h00_0010_5A);
    chk("oor_bytes", 64'(rom_bytes), 64'd1);
    chk("oor_sum", 64'(rom_sum), 64'h005A);
    ioctl_download = 1'b0;
    repeat (4) tick();
    chk("hold_crst", 64'(core_reset), 64'd1);
    ioctl_download = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("reent_crst", 64'(core_reset), 64'd1);
      chk("reent_no_done", 64'(load_done), 64'd0);
    end
    chk("reent_bytes", 64'(rom_bytes), 64'd0);
    chk("reent_sum", 64'(rom_sum), 64'd0);
    wr(8'd0, 25'd5, 8'h11);
    repeat (2) tick();
    chk("reent_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() > 1) chk("reent_xfer", 64'(got_q[1]), 64'h00_0005_11);
    chk("reent_bytes2", 64'(rom_bytes), 64'd1);
    end_load();

    // ---------------- async reset mid-load ----------------
    wr(8'd1, 25'd0, 8'h3C);
    chk("ar_mod_set", 64'(mod), 64'h3C);
    rom_ready = 1'b0;
    start_load();
    for (int i = 0; i < 4; i++) wr(8'd0, 25'(16'h0200 + i), 8'(8'h90 + i));
    chk("ar_wait_pre", 64'(ioctl_wait), 64'd1);
    chk("ar_wr_pre", 64'(rom_wr), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_rom_wr", 64'(rom_wr), 64'd0);
    chk("ar_crst", 64'(core_reset), 64'd0);
    chk("ar_wait", 64'(ioctl_wait), 64'd0);
    chk("ar_mod", 64'(mod), 64'd0);
    chk("ar_dip", dip_sw, 64'd0);
    ioctl_download = 1'b0;
    rom_ready      = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    got_q.delete();
    repeat (20) tick();
    chk("ar_no_stale", 64'(got_q.size()), 64'd0);
    chk("ar_wr_after", 64'(rom_wr), 64'd0);
    chk("ar_crst_after", 64'(core_reset), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
